ysyx_23060124_wb_arbiter: RTL
=============================

Name: ysyx_23060124_wb_arbiter

Overview:
Write-back arbiter/sequencer between the two result producers (EXU: ALU/CSR/branch results; LSU: load data) and the single GPR/CSR write port plus PC-redirect path of the WBU. Grants at most one producer per cycle with round-robin fairness and registers the selected write. It sequences PC redirects with a post-redirect flush window during which no new results are accepted.

Parameters:
FLUSH_CYCLES, 1, cycles both readies are held low after a redirect is issued (legal range 1..7).
XLEN, 32, data and PC width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
i_exu_valid  in  1  EXU result valid
o_exu_ready  out  1  EXU result accepted this cycle
i_exu_wen  in  1  EXU GPR write enable
i_exu_rd  in  4  EXU destination register (RV32E)
i_exu_res  in  XLEN  EXU result
i_exu_csr_wen  in  1  CSR write enable
i_exu_csr_addr  in  12  CSR address
i_exu_redirect  in  1  jal/jalr/taken branch/ecall/mret
i_exu_pc_next  in  XLEN  redirect target
i_lsu_valid  in  1  LSU load result valid
o_lsu_ready  out  1  LSU result accepted this cycle
i_lsu_rd  in  4  load destination register
i_lsu_rdata  in  XLEN  load data
o_rf_wen  out  1  GPR write strobe
o_rf_waddr  out  4  GPR write address
o_rf_wdata  out  XLEN  GPR write data
o_csr_wen  out  1  CSR write strobe
o_csr_addr  out  12  CSR address
o_csr_wdata  out  XLEN  CSR write data
o_pc_update  out  1  one-cycle PC redirect pulse
o_pc_next  out  XLEN  redirect target, valid with o_pc_update
o_retire  out  1  one-cycle pulse per accepted result

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rr pointer=EXU; flush counter=0; all outputs 0. Reset asserted mid-FLUSH aborts the flush, so the block is in IDLE on the first cycle after reset.
- States: IDLE (arbitrating) and FLUSH (blocking).
- IDLE grant:
  - Only one valid requester: grant it.
  - Both valid: grant the side named by the rr pointer.
  - After each grant, rr pointer moves to the non-granted side.
  - ready is combinational from valid/state/pointer. Transfer occurs on valid&&ready.
  - Requester must hold payload stable until accepted. An unaccepted requester is never dropped.
- FLUSH: o_exu_ready=o_lsu_ready=0 regardless of valid.
- Latency: outputs registered; the cycle after a transfer they present the transaction. In every other cycle all strobes (o_rf_wen, o_csr_wen, o_pc_update, o_retire) are 0.
- GPR write:
  - o_rf_wen=i_*_wen && rd!=0. LSU wen is implicitly 1.
  - Writes to x0 are suppressed but still pulse o_retire.
- CSR write:
  - EXU only; o_csr_wen=i_exu_csr_wen.
  - o_csr_wdata=i_exu_res.
  - The same transaction may also write a GPR (csrrw).
- Redirect:
  - Accepted EXU with redirect=1 gives o_pc_update=1 and o_pc_next=target the next cycle, for exactly one cycle. Otherwise o_pc_next=0.
  - The same accept edge enters FLUSH with counter=FLUSH_CYCLES.
  - Counter decrements each FLUSH cycle; at 1→0 the block returns to IDLE, so arbitration resumes FLUSH_CYCLES cycles after the accept edge.
  - A redirect and a GPR write in one transaction (jal rd) produce both strobes in the same cycle.
- Back-to-back: one transfer per cycle sustained in IDLE with no bubble.

Optional Feature:
YSYX_23060124_WBARB_PERF_EN
- Defined: adds 32-bit saturating counters for EXU grants, LSU grants, conflict cycles (both valid) and flush cycles, exposed as output ports o_perf_exu, o_perf_lsu, o_perf_conflict, o_perf_flush; reset to 0.
- Undefined: ports and counters absent; no functional difference.

Decomposition:
- Shared package ysyx_23060124_wb_pkg holds:
  - state encoding (IDLE=0, FLUSH=1)
  - requester index constants (REQ_EXU=0, REQ_LSU=1)
  - RV32E register-address width constant (4)
- One natural sub-module, ysyx_23060124_rr_arb2: 2-way round-robin grant with pointer register (valid[1:0], advance → grant[1:0]).

Test Plan:
- Single EXU write rd=5 res=0xDEADBEEF → ready same cycle; next cycle o_rf_wen=1 waddr=5 wdata=0xDEADBEEF o_retire=1; following cycle strobes 0.
- Both valid continuously for 4 cycles after reset (EXU rd=1, LSU rd=2) → grants EXU,LSU,EXU,LSU; each ready held until accepted; no payload lost.
- EXU jal rd=1 redirect pc_next=0x80000100 with FLUSH_CYCLES=2, LSU valid → next cycle o_pc_update=1 o_pc_next=0x80000100 o_rf_wen=1; readies 0 for 2 cycles; LSU accepted on the third cycle.
- EXU rd=0 wen=1 res=0x1234 → o_rf_wen=0, o_retire=1.
- csrrw csr_addr=0x341 res=0x80000004 rd=3 → o_csr_wen=1 addr=0x341 and o_rf_wen=1 waddr=3 in the same cycle.
- Reset asserted during FLUSH → first post-reset cycle IDLE, valid EXU accepted immediately, all outputs 0 during reset.

Source files
------------

// File: rtl/ysyx_23060124_wb_pkg.sv
// Shared definitions for the write-back arbiter: state encoding,
// requester indices, RV32E register-address width and small helpers.
package ysyx_23060124_wb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam int REQ_EXU = 0;
    localparam int REQ_LSU = 1;

    localparam int REG_AW = 4;

    // x0 is hardwired to zero, so a write to it never strobes the file
    function automatic logic gpr_wen(input logic wen, input logic [REG_AW-1:0] rd);
        return wen && (rd != '0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ysyx_23060124_rr_arb2.sv
// 2-way round-robin arbiter. Ports: clock, reset, valid[1:0] requests,
// advance (a grant was taken), grant[1:0] one-hot combinational grant.
module ysyx_23060124_rr_arb2
    import ysyx_23060124_wb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr names the side preferred on a conflict (0 = EXU, 1 = LSU)
    logic ptr;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            // hand priority to whichever side did not win
            ptr <= grant[REQ_EXU];
        end
    end

endmodule

// File: rtl/ysyx_23060124_wb_arbiter.sv
// Write-back arbiter: picks EXU or LSU result, registers the GPR/CSR write,
// issues PC redirects and blocks both producers for FLUSH_CYCLES afterwards.
// Ports: clock/reset; i_exu_* / i_lsu_* requests with o_*_ready; o_rf_*,
// o_csr_*, o_pc_update/o_pc_next, o_retire registered outputs.
// Optional YSYX_23060124_WBARB_PERF_EN adds o_perf_exu/lsu/conflict/flush.
module ysyx_23060124_wb_arbiter
    import ysyx_23060124_wb_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int XLEN         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_exu_valid,
    output logic              o_exu_ready,
    input  logic              i_exu_wen,
    input  logic [REG_AW-1:0] i_exu_rd,
    input  logic [XLEN-1:0]   i_exu_res,
    input  logic              i_exu_csr_wen,
    input  logic [11:0]       i_exu_csr_addr,
    input  logic              i_exu_redirect,
    input  logic [XLEN-1:0]   i_exu_pc_next,
    input  logic              i_lsu_valid,
    output logic              o_lsu_ready,
    input  logic [REG_AW-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]   i_lsu_rdata,
    output logic              o_rf_wen,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [XLEN-1:0]   o_rf_wdata,
    output logic              o_csr_wen,
    output logic [11:0]       o_csr_addr,
    output logic [XLEN-1:0]   o_csr_wdata,
    output logic              o_pc_update,
    output logic [XLEN-1:0]   o_pc_next,
    output logic              o_retire
`ifdef YSYX_23060124_WBARB_PERF_EN
    ,
    output logic [31:0]       o_perf_exu,
    output logic [31:0]       o_perf_lsu,
    output logic [31:0]       o_perf_conflict,
    output logic [31:0]       o_perf_flush
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    logic [0:0] state;
    logic [2:0] cnt;
    logic [1:0] req;
    logic [1:0] grant;
    logic       xfer_exu;
    logic       xfer_lsu;

    // nothing is offered to the arbiter while flushing or in reset
    assign req = (state == ST_IDLE && !reset) ? {i_lsu_valid, i_exu_valid} : 2'b00;

    ysyx_23060124_rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .valid   (req),
        .advance (grant != 2'b00),
        .grant   (grant)
    );

    assign xfer_exu    = grant[REQ_EXU];
    assign xfer_lsu    = grant[REQ_LSU];
    assign o_exu_ready = xfer_exu;
    assign o_lsu_ready = xfer_lsu;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_rf_wen    <= 1'b0;
            o_rf_waddr  <= '0;
            o_rf_wdata  <= '0;
            o_csr_wen   <= 1'b0;
            o_csr_addr  <= '0;
            o_csr_wdata <= '0;
            o_pc_update <= 1'b0;
            o_pc_next   <= '0;
            o_retire    <= 1'b0;
        end else begin
            o_rf_wen    <= 1'b0;
            o_rf_waddr  <= '0;
            o_rf_wdata  <= '0;
            o_csr_wen   <= 1'b0;
            o_csr_addr  <= '0;
            o_csr_wdata <= '0;
            o_pc_update <= 1'b0;
            o_pc_next   <= '0;
            o_retire    <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (xfer_exu && i_exu_redirect) begin
                        state <= ST_FLUSH;
                        cnt   <= FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (xfer_exu) begin
                o_retire    <= 1'b1;
                o_rf_wen    <= gpr_wen(i_exu_wen, i_exu_rd);
                o_rf_waddr  <= i_exu_rd;
                o_rf_wdata  <= i_exu_res;
                o_csr_wen   <= i_exu_csr_wen;
                o_csr_addr  <= i_exu_csr_addr;
                o_csr_wdata <= i_exu_res;
                o_pc_update <= i_exu_redirect;
                o_pc_next   <= i_exu_redirect ? i_exu_pc_next : '0;
            end else if (xfer_lsu) begin
                o_retire   <= 1'b1;
                o_rf_wen   <= gpr_wen(1'b1, i_lsu_rd);
                o_rf_waddr <= i_lsu_rd;
                o_rf_wdata <= i_lsu_rdata;
            end
        end
    end

`ifdef YSYX_23060124_WBARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            o_perf_exu      <= '0;
            o_perf_lsu      <= '0;
            o_perf_conflict <= '0;
            o_perf_flush    <= '0;
        end else begin
            if (xfer_exu) o_perf_exu <= sat_inc(o_perf_exu);
            if (xfer_lsu) o_perf_lsu <= sat_inc(o_perf_lsu);
            if (i_exu_valid && i_lsu_valid) o_perf_conflict <= sat_inc(o_perf_conflict);
            if (state == ST_FLUSH) o_perf_flush <= sat_inc(o_perf_flush);
        end
    end
`endif

endmodule
